// File: rtl/nec_pkg.sv
// Shared types and constants for the NEC IR decoder with frame FIFO.
package nec_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLeadMark  = 3'd1,
    StLeadSpace = 3'd2,
    StBitMark   = 3'd3,
    StBitSpace  = 3'd4,
    StStopMark  = 3'd5,
    StRptMark   = 3'd6
  } nec_state_e;

  typedef struct packed {
    logic        rpt;
    logic [31:0] frame;
  } fifo_entry_t;

  localparam logic [3:0] RegCsr    = 4'h0;
  localparam logic [3:0] RegPeriod = 4'h4;
  localparam logic [3:0] RegData   = 4'h8;
  localparam logic [3:0] RegStatus = 4'hC;

  localparam int unsigned CsrEn      = 0;
  localparam int unsigned CsrIrqEn   = 1;
  localparam int unsigned CsrStrict  = 2;
  localparam int unsigned CsrFifoClr = 3;
  localparam int unsigned CsrOvf     = 8;
  localparam int unsigned CsrErr     = 9;

  // Pulse-length windows in 562.5 us units.
  localparam logic [5:0] LeadMarkMin  = 6'd14;
  localparam logic [5:0] LeadMarkMax  = 6'd18;
  localparam logic [5:0] LeadSpaceMin = 6'd7;
  localparam logic [5:0] LeadSpaceMax = 6'd9;
  localparam logic [5:0] RptSpaceMin  = 6'd3;
  localparam logic [5:0] RptSpaceMax  = 6'd5;
  localparam logic [5:0] ShortMin     = 6'd1;
  localparam logic [5:0] ShortMax     = 6'd2;
  localparam logic [5:0] OneMin       = 6'd3;
  localparam logic [5:0] OneMax       = 6'd4;

  function automatic logic in_win(logic [5:0] len, logic [5:0] lo, logic [5:0] hi);
    return (len >= lo) && (len <= hi);
  endfunction

endpackage

// File: rtl/nec_frame_fifo.sv
// Synchronous frame FIFO; push while full is dropped, clear has priority.
module nec_frame_fifo import nec_pkg::*; #(
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t data_i,
  input  logic        pop_i,
  input  logic        clr_i,
  output fifo_entry_t data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [Aw:0] level_o
);

  fifo_entry_t   mem_q [Depth];
  logic [Aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [Aw:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (Aw+1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (Aw+1)'(do_push) - (Aw+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/nec_decoder_fifo.sv
// NEC IR receiver with AXI4-Lite CSRs and a frame FIFO.
// Define NEC_EXT_ADDR_EN for 16-bit extended addresses (STRICT then checks only the command pair).
module nec_decoder_fifo import nec_pkg::*; #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned DEF_PERIOD     = 56250,
  parameter int unsigned GLITCH_CYC     = 16,
  parameter bit          RX_ACTIVE_HIGH = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        data_rx,
  output logic        irq,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int unsigned Aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned Gw = $clog2(GLITCH_CYC + 1);
  localparam logic RxIdle = !RX_ACTIVE_HIGH;
`ifdef NEC_EXT_ADDR_EN
  localparam logic ExtAddr = 1'b1;
`else
  localparam logic ExtAddr = 1'b0;
`endif

  logic [1:0]    sync_q;
  logic          filt_q, mark_q, mark, rise, fall;
  logic [Gw-1:0] glitch_q;
  logic [19:0]   sub_q, period_q;
  logic [4:0]    unit_q, bits_q, bits_d;
  logic [5:0]    len;
  nec_state_e    state_q, state_d;
  logic [31:0]   shreg_q, shreg_d, last_q, rd_data, rdata_q;
  logic          have_last_q, push, store, err_set, fail, pair_ok;
  fifo_entry_t   push_entry, head;
  logic          fifo_full, fifo_empty, fifo_clr, fifo_pop;
  logic [Aw:0]   fifo_level;
  logic          en_q, irq_en_q, strict_q, ovf_q, err_q, irq_q;
  logic          awready_q, bvalid_q, arready_q, rvalid_q, rvalid_d, wr_fire, rd_fire, wr_csr;
  logic          unused_wr;

  assign unused_wr = ^{S_AXI_WSTRB, S_AXI_WDATA[31:20]};

  // Input conditioning: synchroniser, glitch filter, polarity fix.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync_q   <= {2{RxIdle}};
      filt_q   <= RxIdle;
      glitch_q <= '0;
      mark_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], data_rx};
      mark_q <= mark;
      if (sync_q[1] == filt_q) begin
        glitch_q <= '0;
      end else if (glitch_q == Gw'(GLITCH_CYC - 1)) begin
        filt_q   <= sync_q[1];
        glitch_q <= '0;
      end else begin
        glitch_q <= glitch_q + 1'b1;
      end
    end
  end

  assign mark = filt_q ^ RxIdle;
  assign rise = mark && !mark_q;
  assign fall = !mark && mark_q;
  assign len  = {1'b0, unit_q} + 6'(sub_q >= {1'b0, period_q[19:1]});

`ifdef NEC_EXT_ADDR_EN
  assign pair_ok = (shreg_q[31:24] == ~shreg_q[23:16]);
`else
  assign pair_ok = (shreg_q[31:24] == ~shreg_q[23:16]) && (shreg_q[15:8] == ~shreg_q[7:0]);
`endif

  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    push_entry = '0;
    store      = 1'b0;
    err_set    = 1'b0;
    fail       = 1'b0;
    case (state_q)
      StIdle:      if (rise) state_d = StLeadMark;
      StLeadMark:  if (fall) begin
        if (in_win(len, LeadMarkMin, LeadMarkMax)) state_d = StLeadSpace;
        else fail = 1'b1;
      end
      StLeadSpace: if (rise) begin
        if (in_win(len, LeadSpaceMin, LeadSpaceMax)) begin
          state_d = StBitMark;
          bits_d  = '0;
        end else if (in_win(len, RptSpaceMin, RptSpaceMax)) begin
          state_d = StRptMark;
        end else fail = 1'b1;
      end
      StBitMark:   if (fall) begin
        if (in_win(len, ShortMin, ShortMax)) state_d = StBitSpace;
        else fail = 1'b1;
      end
      StBitSpace:  if (rise) begin
        if (in_win(len, ShortMin, ShortMax) || in_win(len, OneMin, OneMax)) begin
          shreg_d = {in_win(len, OneMin, OneMax), shreg_q[31:1]};
          bits_d  = bits_q + 5'd1;
          state_d = (bits_q == 5'd31) ? StStopMark : StBitMark;
        end else fail = 1'b1;
      end
      StStopMark:  if (fall) begin
        if (!in_win(len, ShortMin, ShortMax)) fail = 1'b1;
        else begin
          state_d = StIdle;
          if (strict_q && !pair_ok) err_set = 1'b1;
          else begin
            push       = 1'b1;
            push_entry = '{rpt: 1'b0, frame: shreg_q};
            store      = 1'b1;
          end
        end
      end
      StRptMark:   if (fall) begin
        if (!in_win(len, ShortMin, ShortMax)) fail = 1'b1;
        else begin
          state_d    = StIdle;
          push       = have_last_q;
          push_entry = '{rpt: 1'b1, frame: last_q};
        end
      end
      default:     state_d = StIdle;
    endcase
    if (state_q != StIdle && !mark && unit_q == 5'd31) fail = 1'b1;
    if (fail) begin
      err_set = 1'b1;
      state_d = StIdle;
    end
    if (!en_q) begin
      state_d = StIdle;
      push    = 1'b0;
      store   = 1'b0;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= StIdle;
      bits_q      <= '0;
      shreg_q     <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      sub_q       <= '0;
      unit_q      <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      if (store) last_q <= shreg_q;
      if (!en_q)      have_last_q <= 1'b0;
      else if (store) have_last_q <= 1'b1;
      if (rise || fall) begin
        sub_q  <= '0;
        unit_q <= '0;
      end else if (sub_q >= period_q - 20'd1) begin
        sub_q <= '0;
        if (unit_q != 5'd31) unit_q <= unit_q + 5'd1;
      end else begin
        sub_q <= sub_q + 20'd1;
      end
    end
  end

  nec_frame_fifo #(.Depth(FIFO_DEPTH)) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .clr_i   (fifo_clr),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign wr_fire  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire  = arready_q && S_AXI_ARVALID;
  assign wr_csr   = wr_fire && (S_AXI_AWADDR == RegCsr);
  assign fifo_clr = wr_csr && S_AXI_WDATA[CsrFifoClr];
  assign fifo_pop = rd_fire && (S_AXI_ARADDR == RegData) && !fifo_empty;
  assign rvalid_d = rd_fire ? 1'b1 : (S_AXI_RREADY ? 1'b0 : rvalid_q);

  always_comb begin
    rd_data = '0;
    case (S_AXI_ARADDR)
      RegCsr:    rd_data = {8'h0, 8'(fifo_level), 6'h0, err_q, ovf_q, 5'h0, strict_q, irq_en_q, en_q};
      RegPeriod: rd_data = {12'h0, period_q};
      RegData:   rd_data = fifo_empty ? 32'h0 : head.frame;
      RegStatus: rd_data = {28'h0, ExtAddr, fifo_full, fifo_empty, !fifo_empty && head.rpt};
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      strict_q  <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      period_q  <= 20'(DEF_PERIOD);
    end else begin
      awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      if (wr_fire)           bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      rvalid_q  <= rvalid_d;
      arready_q <= !rvalid_d;
      if (rd_fire) rdata_q <= rd_data;
      if (wr_csr) begin
        en_q     <= S_AXI_WDATA[CsrEn];
        irq_en_q <= S_AXI_WDATA[CsrIrqEn];
        strict_q <= S_AXI_WDATA[CsrStrict];
      end
      if (wr_fire && S_AXI_AWADDR == RegPeriod) period_q <= S_AXI_WDATA[19:0];
      // A new event wins over a same-cycle W1C.
      ovf_q <= (push && fifo_full) || (ovf_q && !(wr_csr && S_AXI_WDATA[CsrOvf]));
      err_q <= err_set || (err_q && !(wr_csr && S_AXI_WDATA[CsrErr]));
      irq_q <= irq_en_q && (!fifo_empty || ovf_q || err_q);
    end
  end

  assign irq           = irq_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_nec_decoder_fifo.sv
// Randomised bench for nec_decoder_fifo against a frame-level queue model.
`timescale 1ns/1ps
module tb_nec_decoder_fifo;

  localparam int unsigned Depth  = 4;
  localparam int unsigned Period = 16;
  localparam int unsigned Glitch = 4;

  logic        clk = 1'b0, rst_n = 1'b0, data_rx = 1'b0, irq;
  logic [3:0]  awaddr = '0, araddr = '0, wstrb = 4'hF;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  nec_decoder_fifo #(
    .FIFO_DEPTH(Depth), .DEF_PERIOD(56250), .GLITCH_CYC(Glitch), .RX_ACTIVE_HIGH(1'b1)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .data_rx(data_rx), .irq(irq),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  int n_checks = 0, n_fail = 0;

  typedef struct packed { logic rpt; logic [31:0] frame; } entry_t;
  entry_t      m_q[$];
  logic        m_have = 1'b0, m_ovf = 1'b0, m_err = 1'b0, m_strict = 1'b0, m_irqen = 1'b0;
  logic [31:0] m_last = '0;
`ifdef NEC_EXT_ADDR_EN
  localparam logic MExt = 1'b1;
`else
  localparam logic MExt = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check_eq("awready_seen", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check_eq("arready_seen", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check_eq("rvalid_seen", 32'(rvalid), 32'd1);
    d = rdata; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // ---------- reference model (frame level) ----------
  function automatic logic pair_ok(input logic [31:0] f);
    logic ok;
    ok = (f[31:24] == ~f[23:16]);
    if (!MExt) ok = ok && (f[15:8] == ~f[7:0]);
    return ok;
  endfunction

  task automatic m_push(input entry_t e);
    if (m_q.size() == Depth) m_ovf = 1'b1;
    else m_q.push_back(e);
  endtask

  task automatic write_csr(input logic [31:0] v);
    axi_write(4'h0, v);
    m_strict = v[2]; m_irqen = v[1];
    if (!v[0]) m_have = 1'b0;
    if (v[3]) m_q.delete();
    if (v[8]) m_ovf = 1'b0;
    if (v[9]) m_err = 1'b0;
  endtask

  // ---------- IR waveform generation ----------
  task automatic ir_level(input logic v, input int units);
    data_rx = v;
    repeat (units * Period) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f);
    ir_level(1'b1, 16); ir_level(1'b0, 8);
    for (int i = 0; i < 32; i++) begin
      ir_level(1'b1, 1); ir_level(1'b0, f[i] ? 3 : 1);
    end
    ir_level(1'b1, 1); ir_level(1'b0, 4);
    if (m_strict && !pair_ok(f)) m_err = 1'b1;
    else begin
      m_last = f; m_have = 1'b1;
      m_push('{rpt: 1'b0, frame: f});
    end
  endtask

  task automatic send_repeat();
    ir_level(1'b1, 16); ir_level(1'b0, 4); ir_level(1'b1, 1); ir_level(1'b0, 4);
    if (m_have) m_push('{rpt: 1'b1, frame: m_last});
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d, e;
    e = (m_q.size() != 0) ? m_q[0].frame : 32'h0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    axi_read(4'h8, d);
    check_eq(tag, d, e);
  endtask

  task automatic check_state(input string tag);
    logic [31:0] d;
    logic        emp, rpt, full;
    emp  = (m_q.size() == 0);
    full = (m_q.size() == Depth);
    rpt  = !emp && m_q[0].rpt;
    axi_read(4'h0, d);
    check_eq({tag, "_level"}, {24'h0, d[23:16]}, 32'(m_q.size()));
    check_eq({tag, "_ovf_err"}, {30'h0, d[9:8]}, {30'h0, m_err, m_ovf});
    axi_read(4'hC, d);
    check_eq({tag, "_status"}, d, {28'h0, MExt, full, emp, rpt});
    check_eq({tag, "_irq"}, 32'(irq), 32'(m_irqen && (!emp || m_ovf || m_err)));
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_axi_ctl"}, {25'h0, awready, wready, bvalid, arready, rvalid, bresp[0], rresp[0]},
             32'h0);
    check_eq({tag, "_rdata"}, rdata, 32'h0);
    check_eq({tag, "_irq"}, 32'(irq), 32'h0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_have = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_strict = 1'b0; m_irqen = 1'b0; m_last = '0;
  endtask

  initial begin
    logic [31:0] d, f;
    logic [7:0]  a, c;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(4'h4, d);
    check_eq("period_rst", d, 32'd56250);
    axi_read(4'h0, d);
    check_eq("csr_rst", d, 32'h0);
    check_state("rst");

    axi_write(4'h4, Period);
    write_csr(32'h3);

    // Reference frame, then the same frame followed by a repeat.
    send_frame(32'hEE117887);
    check_state("f1");
    read_data("f1_data");
    check_eq("f1_const", m_last, 32'hEE117887);
    check_state("f1_drained");
    send_frame(32'hEE117887);
    send_repeat();
    check_state("rpt");
    read_data("rpt_first");
    check_state("rpt_head");
    read_data("rpt_second");
    read_data("empty_read");

    // Strict pair failure, then W1C of ERR.
    write_csr(32'h7);
    send_frame(32'hEF117887);
    check_state("strict");
    write_csr(32'h7 | (32'h1 << 9));
    repeat (3) @(negedge clk);
    check_state("err_w1c");
    write_csr(32'h3);

    // Overflow: one frame more than the FIFO holds.
    for (int i = 0; i <= Depth; i++) begin
      a = 8'($urandom); c = 8'($urandom);
      send_frame({~c, c, ~a, a});
    end
    check_state("ovf");
    for (int i = 0; i <= Depth; i++) read_data("ovf_drain");
    write_csr(32'h3 | (32'h1 << 8));
    check_state("ovf_w1c");

    // Lone short mark is an error; a sub-filter glitch is ignored.
    ir_level(1'b1, 1); ir_level(1'b0, 4);
    m_err = 1'b1;
    data_rx = 1'b1; repeat (Glitch - 1) @(negedge clk);
    ir_level(1'b0, 2);
    check_state("lone_mark");
    write_csr(32'h3 | (32'h1 << 9));
    check_state("lone_w1c");

    // Randomised mix of frames, repeats, strict toggles, clears and reads.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 9) < 2) send_repeat();
      else begin
        a = 8'($urandom); c = 8'($urandom);
        f = {~c, c, ~a, a};
        if ($urandom_range(0, 3) == 0) f = f ^ (32'h1 << $urandom_range(0, 31));
        send_frame(f);
      end
      if ($urandom_range(0, 3) == 0) write_csr(32'h3 | (32'($urandom_range(0, 1)) << 2));
      if ($urandom_range(0, 7) == 0) write_csr({30'h0, m_strict, 1'b1} | 32'h9);
      if ($urandom_range(0, 1) == 0) read_data("rnd_data");
      check_state("rnd");
    end
    while (m_q.size() != 0) read_data("rnd_drain");
    write_csr(32'h3 | (32'h3 << 8));

    // Reset in the middle of a frame.
    ir_level(1'b1, 16); ir_level(1'b0, 8);
    for (int i = 0; i < 10; i++) begin ir_level(1'b1, 1); ir_level(1'b0, 3); end
    rst_n = 1'b0; data_rx = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("midrst");
    model_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(4'h4, d);
    check_eq("period_midrst", d, 32'd56250);
    axi_write(4'h4, Period);
    write_csr(32'h3);
    send_frame(32'h9D62BF40);
    check_state("post_rst");
    read_data("post_rst_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
